// File: rtl/rf_scan_ctrl_if.sv
// Bulk-transfer port bundle for rf_scan_ctrl: control, register-file port 1, dump and load streams.
// master = the scan controller, slave = the surrounding CPU / stream environment.
interface rf_scan_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int REGBITS    = 4
);
  logic                  start;
  logic                  mode;
  logic [REGBITS-1:0]    start_addr;
  logic [REGBITS-1:0]    end_addr;
  logic                  abort;

  logic [REGBITS-1:0]    rf_addr;
  logic                  rf_wr_en;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic [DATA_WIDTH-1:0] rf_rd_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    input  start, mode, start_addr, end_addr, abort,
    input  rf_rd_data, out_ready, in_valid, in_data,
    output rf_addr, rf_wr_en, rf_wr_data,
    output out_valid, out_data, out_last, in_ready,
    output busy, done, checksum
  );

  modport slave (
    output start, mode, start_addr, end_addr, abort,
    output rf_rd_data, out_ready, in_valid, in_data,
    input  rf_addr, rf_wr_en, rf_wr_data,
    input  out_valid, out_data, out_last, in_ready,
    input  busy, done, checksum
  );
endinterface

// File: rtl/rf_scan_ctrl.sv
// Register-file scan controller: dumps a wrapping register range to a stream or loads it from one.
// One word per cycle, first word in the cycle after start; optional running sum under RF_SCAN_CHECKSUM_EN.
module rf_scan_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int REGBITS    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [REGBITS:0]   CNT_ONE = 1;
  localparam logic [REGBITS-1:0] PTR_ONE = 1;

  state_t             r_state;
  logic [REGBITS-1:0] r_ptr;
  logic [REGBITS:0]   r_remaining;
  logic               r_busy;
  logic               r_done;

  logic               w_in_dump;
  logic               w_in_load;
  logic               w_accept;
  logic               w_dump_xfer;
  logic               w_load_xfer;
  logic               w_xfer;
  logic               w_last;
  logic [REGBITS-1:0] w_span;
  logic [REGBITS:0]   w_count;

  assign w_in_dump   = (r_state == S_DUMP);
  assign w_in_load   = (r_state == S_LOAD);
  assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_dump_xfer = w_in_dump && !bus.abort && bus.out_ready;
  assign w_load_xfer = w_in_load && !bus.abort && bus.in_valid;
  assign w_xfer      = w_dump_xfer || w_load_xfer;
  assign w_last      = (r_remaining == CNT_ONE);

  // Modular subtraction gives the wrapped span; a span of N-1 needs the extra count bit.
  assign w_span  = bus.end_addr - bus.start_addr;
  assign w_count = {1'b0, w_span} + CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_ptr       <= bus.start_addr;
            r_remaining <= w_count;
            r_busy      <= 1'b1;
            r_state     <= bus.mode ? S_LOAD : S_DUMP;
          end
        end
        S_DUMP, S_LOAD: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            r_ptr       <= r_ptr + PTR_ONE;
            r_remaining <= r_remaining - CNT_ONE;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Abort masks every handshake in its own cycle so nothing moves while cancelling.
  assign bus.rf_addr    = (w_in_dump || w_in_load) ? r_ptr : '0;
  assign bus.out_valid  = w_in_dump && !bus.abort;
  assign bus.out_last   = w_in_dump && !bus.abort && w_last;
  assign bus.out_data   = w_in_dump ? bus.rf_rd_data : '0;
  assign bus.in_ready   = w_in_load && !bus.abort;
  assign bus.rf_wr_en   = w_in_load && !bus.abort && bus.in_valid;
  assign bus.rf_wr_data = w_in_load ? bus.in_data : '0;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done && !bus.abort;

`ifdef RF_SCAN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_word = w_dump_xfer ? bus.rf_rd_data : bus.in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + w_word;
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

endmodule
